// File: rtl/core_inst_seq.sv
// Instruction sequencer for the systolic core: walks weight load, weight execute,
// activation load, execute and output drain, emitting one registered 34-bit word per cycle.
module core_inst_seq #(
   parameter int unsigned row = 8,
   parameter int unsigned col = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mode,
   input  logic [9:0]  w_base,
   input  logic [9:0]  x_base,
   input  logic [9:0]  x_len,
   input  logic [10:0] p_base,
   input  logic        valid,
   output logic [33:0] inst,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      StIdle, StWload, StWexec, StXload, StXexec, StDrain, StDone
   } state_e;

   localparam logic [10:0] RowC = 11'(row);
   localparam logic [10:0] ColC = 11'(col);
   localparam logic [33:0] ResetWord = 34'h1_800C_0000;

   state_e      state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic [9:0]  k_q, k_d;
   logic [9:0]  wd_q, wd_d;
   logic        mode_q, mode_d;
   logic [9:0]  wbase_q, wbase_d, xbase_q, xbase_d, xlen_q, xlen_d;
   logic [10:0] pbase_q, pbase_d;
   logic        err_d;
   logic [33:0] inst_d;

   logic        acc, p_cen, p_wen, x_cen, ofifo_rd, l0_rd, l0_wr, execute, load;
   logic [10:0] p_addr;
   logic [9:0]  x_idx;
   logic [10:0] xlen11;
   logic        count_valid;

   assign xlen11 = {1'b0, xlen_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      k_d      = k_q;
      wd_d     = wd_q;
      mode_d   = mode_q;
      wbase_d  = wbase_q;
      xbase_d  = xbase_q;
      xlen_d   = xlen_q;
      pbase_d  = pbase_q;
      err_d    = err;
      acc      = 1'b0;
      p_cen    = 1'b1;
      p_wen    = 1'b1;
      p_addr   = 11'd0;
      x_cen    = 1'b1;
      x_idx    = 10'd0;
      ofifo_rd = 1'b0;
      l0_rd    = 1'b0;
      l0_wr    = 1'b0;
      execute  = 1'b0;
      load     = 1'b0;

      // Output vectors are only counted once execution has begun and until all are stored.
      count_valid = valid && (state_q == StXexec || state_q == StDrain) && (k_q < xlen_q);
      if (count_valid) begin
         acc      = mode_q;
         p_cen    = 1'b0;
         p_wen    = 1'b0;
         p_addr   = pbase_q + {1'b0, k_q};
         ofifo_rd = 1'b1;
         k_d      = k_q + 10'd1;
         wd_d     = 10'd0;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               mode_d  = mode;
               wbase_d = w_base;
               xbase_d = x_base;
               xlen_d  = x_len;
               pbase_d = p_base;
               err_d   = 1'b0;
               k_d     = 10'd0;
               cnt_d   = 11'd0;
               if (x_len == 10'd0) begin
                  state_d = StDone;
               end else begin
                  state_d = StWload;
                  x_cen   = 1'b0;
                  x_idx   = w_base;
               end
            end
         end
         StWload: begin
            if (cnt_q == RowC) begin
               state_d = StWexec;
               cnt_d   = 11'd0;
               l0_rd   = 1'b1;
               load    = 1'b1;
            end else begin
               cnt_d = cnt_q + 11'd1;
               l0_wr = 1'b1;
               if (cnt_d < RowC) begin
                  x_cen = 1'b0;
                  x_idx = wbase_q + cnt_d[9:0];
               end
            end
         end
         StWexec: begin
            if (cnt_q == ColC - 11'd1) begin
               state_d = StXload;
               cnt_d   = 11'd0;
               x_cen   = 1'b0;
               x_idx   = xbase_q;
            end else begin
               cnt_d = cnt_q + 11'd1;
               l0_rd = 1'b1;
               load  = 1'b1;
            end
         end
         StXload: begin
            if (cnt_q == xlen11) begin
               state_d = StXexec;
               cnt_d   = 11'd0;
               l0_rd   = 1'b1;
               execute = 1'b1;
            end else begin
               cnt_d = cnt_q + 11'd1;
               l0_wr = 1'b1;
               if (cnt_d < xlen11) begin
                  x_cen = 1'b0;
                  x_idx = xbase_q + cnt_d[9:0];
               end
            end
         end
         StXexec: begin
            if (cnt_q == xlen11 - 11'd1) begin
               state_d = StDrain;
               wd_d    = 10'd0;
            end else begin
               cnt_d   = cnt_q + 11'd1;
               l0_rd   = 1'b1;
               execute = 1'b1;
            end
         end
         StDrain: begin
            if (k_q == xlen_q) begin
               state_d = StDone;
            end else if (!count_valid) begin
               // 1023 consecutive drain cycles without an output vector is a stall.
               if (wd_q == 10'd1022) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  wd_d = wd_q + 10'd1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      inst_d = {acc, p_cen, p_wen, p_addr, x_cen, 1'b1, x_idx, mode_d,
                ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, execute, load};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= 11'd0;
         k_q     <= 10'd0;
         wd_q    <= 10'd0;
         mode_q  <= 1'b0;
         wbase_q <= 10'd0;
         xbase_q <= 10'd0;
         xlen_q  <= 10'd0;
         pbase_q <= 11'd0;
         err     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         inst    <= ResetWord;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         wd_q    <= wd_d;
         mode_q  <= mode_d;
         wbase_q <= wbase_d;
         xbase_q <= xbase_d;
         xlen_q  <= xlen_d;
         pbase_q <= pbase_d;
         err     <= err_d;
         busy    <= (state_d != StIdle);
         done    <= (state_d == StDone);
         inst    <= inst_d;
      end
   end

endmodule

// File: tb/tb_core_inst_seq.sv
// Randomized scoreboard bench for core_inst_seq: expected xmem reads and psum writes are
// queued at start and popped by a monitor whenever the instruction word shows an access.
module tb_core_inst_seq;

   localparam int unsigned ROW = 8;
   localparam int unsigned COL = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [9:0]  w_base = '0, x_base = '0, x_len = '0;
   logic [10:0] p_base = '0;
   logic        valid = 1'b0;
   logic [33:0] inst;
   logic        busy, done, err;

   core_inst_seq #(.row(ROW), .col(COL)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .w_base(w_base),
      .x_base(x_base), .x_len(x_len), .p_base(p_base), .valid(valid),
      .inst(inst), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int vpol = 0;  // 0 none, 1 random, 2 every third cycle, 3 always
   int vph = 0;
   logic exp_mode = 1'b0;
   logic [9:0]  xq[$];
   logic [11:0] pq[$];
   int n_l0wr, n_l0rd, n_load, n_exec, n_ofifo, n_bad;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      vph = (vph + 1) % 3;
      case (vpol)
         1: valid = ($urandom_range(0, 2) == 0);
         2: valid = (vph == 0);
         3: valid = 1'b1;
         default: valid = 1'b0;
      endcase
   end

   // Monitor: every access shown on the instruction word must match the next expected one.
   always @(negedge clk) begin
      if (reset) begin
         if (inst[18] !== 1'b1 || inst[5:4] !== 2'b00) n_bad++;
         if (inst[19] === 1'b0) begin
            if (xq.size() == 0) chk("xmem_unexpected", 1, 0);
            else begin
               chk("xmem_idx", 64'(inst[17:8]), 64'(xq.pop_front()));
               chk("xmem_lsb", 64'(inst[7]), 64'(exp_mode));
            end
         end
         if (inst[32] === 1'b0) begin
            if (pq.size() == 0) chk("psum_unexpected", 1, 0);
            else begin
               chk("psum_acc_addr", 64'({inst[33], inst[30:20]}), 64'(pq.pop_front()));
               chk("psum_wen_ofifo", 64'({inst[31], inst[6]}), 64'(2'b01));
            end
         end
         n_l0wr  += int'(inst[2]);
         n_l0rd  += int'(inst[3]);
         n_load  += int'(inst[0]);
         n_exec  += int'(inst[1]);
         n_ofifo += int'(inst[6]);
      end
   end

   task automatic issue(input logic m, input logic [9:0] wb, xb, xl, input logic [10:0] pb,
                        input bit timeout);
      exp_mode = m;
      n_l0wr = 0; n_l0rd = 0; n_load = 0; n_exec = 0; n_ofifo = 0; n_bad = 0;
      if (xl != 0) begin
         for (int i = 0; i < int'(ROW); i++) xq.push_back(10'(wb + 10'(i)));
         for (int j = 0; j < int'(xl); j++) xq.push_back(10'(xb + 10'(j)));
         if (!timeout)
            for (int k = 0; k < int'(xl); k++) pq.push_back({m, 11'(pb + 11'(k))});
      end
      mode = m; w_base = wb; x_base = xb; x_len = xl; p_base = pb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_op(input logic m, input logic [9:0] wb, xb, xl, input logic [10:0] pb,
                         input int vp, input bit timeout, input bit poke);
      int n;
      int base;
      @(negedge clk);
      vpol = vp;
      issue(m, wb, xb, xl, pb, timeout);
      chk("err_cleared", 64'(err), 0);
      n = 1;
      while (done !== 1'b1 && n < 4000) begin
         if (poke && n == 5) begin
            mode = ~m; x_len = 10'd0; w_base = wb + 10'd300; start = 1'b1;
         end else start = 1'b0;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk("done_seen", 64'(done), 1);
      chk("err_flag", 64'(err), 64'(timeout));
      base = int'(ROW) + 1 + int'(COL) + 2 * int'(xl) + 1;
      if (xl == 0) chk("zero_len_latency", 64'(n), 1);
      if (timeout) chk("watchdog_window", 64'(n >= base + 1022 && n <= base + 1026), 1);
      if (timeout) begin
         valid = 1'b1;  // valid during DONE and the following IDLE must be ignored
         vpol = 3;
      end
      @(negedge clk);
      vpol = 0;
      chk("done_one_cycle", 64'(done), 0);
      chk("busy_after_done", 64'(busy), 0);
      @(negedge clk);
      chk("xq_empty", 64'(xq.size()), 0);
      chk("pq_empty", 64'(pq.size()), 0);
      chk("n_l0wr", 64'(n_l0wr), xl == 0 ? 0 : 64'(int'(ROW) + int'(xl)));
      chk("n_l0rd", 64'(n_l0rd), xl == 0 ? 0 : 64'(int'(COL) + int'(xl)));
      chk("n_load", 64'(n_load), xl == 0 ? 0 : 64'(COL));
      chk("n_exec", 64'(n_exec), 64'(xl));
      chk("n_ofifo", 64'(n_ofifo), timeout ? 0 : 64'(xl));
      chk("fixed_bits", 64'(n_bad), 0);
      if (timeout) chk("err_held", 64'(err), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench time limit");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_inst", 64'(inst), 64'(34'h1_800C_0000));
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_err", 64'(err), 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_without_start", 64'({busy, inst}), 64'({1'b0, 34'h1_800C_0000}));

      run_op(1'b0, 10'd0, 10'd16, 10'd4, 11'd100, 2, 1'b0, 1'b1);
      run_op(1'b1, 10'd40, 10'd60, 10'd2, 11'd500, 1, 1'b0, 1'b0);
      chk("mode_bit_held", 64'(inst[7]), 1);
      run_op(1'b0, 10'd5, 10'd9, 10'd0, 11'd7, 3, 1'b0, 1'b0);
      run_op(1'b0, 10'd1020, 10'd1022, 10'd4, 11'd2047, 3, 1'b0, 1'b0);
      run_op(1'b1, 10'd3, 10'd1022, 10'd2, 11'd2047, 2, 1'b0, 1'b0);
      run_op(1'b0, 10'd8, 10'd20, 10'd3, 11'd30, 0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of the activation load.
      @(negedge clk);
      vpol = 1;
      issue(1'b1, 10'd100, 10'd200, 10'd10, 11'd300, 1'b0);
      repeat (int'(ROW) + int'(COL) + 3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_inst", 64'(inst), 64'(34'h1_800C_0000));
      chk("midrst_busy", 64'(busy), 0);
      xq.delete();
      pq.delete();
      vpol = 0;
      @(negedge clk);
      reset = 1'b1;
      run_op(1'b0, 10'd50, 10'd70, 10'd5, 11'd1000, 3, 1'b0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         run_op(1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom),
                10'($urandom_range(1, 20)), 11'($urandom), 1, 1'b0, r == 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_inst_seq.md
CORE_INST_SEQ -- requirements
Module: core_inst_seq

Interface
REQ-001 Parameter row, default 8, PE rows: weight words loaded per kernel.
REQ-002 Parameter col, default 8, PE columns: weight-load cycles into array.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 start  input  1  one-cycle request, accepted only in IDLE.
REQ-006 mode  input  1  0 = weight stationary, 1 = output stationary; latched at start.
REQ-007 w_base  input  10  xmem word index of first weight word; latched at start.
REQ-008 x_base  input  10  xmem word index of first activation word; latched at start.
REQ-009 x_len  input  10  activation/output vector count; latched at start.
REQ-010 p_base  input  11  psum SRAM start address; latched at start.
REQ-011 valid  input  1  core output-ready strobe, one per output vector.
REQ-012 inst  output  34  registered instruction word to core.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  drain timeout flag, held until next accepted start.

Function
REQ-016 inst fields SHALL be: [33] acc, [32] psum CEN, [31] psum WEN, [30:20] psum addr, [19] xmem CEN, [18] xmem WEN, [17:7] xmem addr, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-017 inst[7] SHALL always equal latched mode; xmem addr field = {10-bit word index, mode}.
REQ-018 Idle word SHALL be: CENs/WENs = 1, psum addr 0, xmem index 0, controls 0, inst[7] = mode.
REQ-019 States SHALL be IDLE, WLOAD, WEXEC, XLOAD, XEXEC, DRAIN, DONE; all outputs registered.
REQ-020 IDLE + start: latch inputs, clear err; x_len = 0 -> DONE, else -> WLOAD.
REQ-021 WLOAD: row+1 cycles; cycles 0..row-1 xmem CEN=0, WEN=1, index w_base+i; l0_wr=1 on cycles 1..row (1-cycle SRAM latency).
REQ-022 WEXEC: col cycles, l0_rd=1, load=1; xmem idle.
REQ-023 XLOAD: x_len+1 cycles; xmem read index x_base+j on cycles 0..x_len-1; l0_wr=1 on cycles 1..x_len.
REQ-024 XEXEC: x_len cycles, l0_rd=1, execute=1; then DRAIN.
REQ-025 On valid in XEXEC or DRAIN with k < x_len, same cycle: ofifo_rd=1, psum CEN=0, WEN=0, addr p_base+k, acc=mode; k increments.
REQ-026 valid in IDLE, WLOAD, WEXEC, XLOAD, DONE, or with k = x_len SHALL be ignored (no write, no count).
REQ-027 DRAIN -> DONE when k = x_len.
REQ-028 DRAIN watchdog: 10-bit counter of cycles without valid, cleared by each counted valid; 1023 -> err=1, go DONE.
REQ-029 DONE: one cycle, done=1, idle word, -> IDLE.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 Index arithmetic: xmem 10-bit wraps mod 1024; psum 11-bit wraps mod 2048.

Reset
REQ-032 reset=0: state IDLE, counters 0, latched regs 0, busy=0, done=0, err=0, inst=34'h1_800C_0000; asynchronous, also mid-operation.
REQ-033 After reset release, first transition SHALL need start on a clock edge.

Verification
REQ-034 Reset mid-XLOAD -> same-instant inst=34'h1_800C_0000, busy=0; next start runs cleanly.
REQ-035 start, mode=0, w_base=0, x_base=16, x_len=4, p_base=100, valid every 3 cycles in DRAIN -> 4 psum writes at 100..103, acc=0, done pulses once.
REQ-036 mode=1, x_len=2 -> inst[7]=1 throughout, xmem addr LSB=1, psum writes with acc=1.
REQ-037 x_len=0 -> IDLE, DONE, IDLE; no xmem/psum access; done one cycle.
REQ-038 x_base=1022, x_len=4 -> xmem indices 1022, 1023, 0, 1; p_base=2047, x_len=2 -> psum 2047, 0.
REQ-039 No valid in DRAIN -> err=1 and done after 1023 cycles; extra valid in DONE ignored; start while busy ignored.
